// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB
// sequencing with a variable-latency memory handshake, wait timeout, illegal-op trap and retire counter.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       instr_op_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             PC_Write_o,
    output logic             IR_Write_o,
    output logic             IorD_o,
    output logic             MEM_Read_o,
    output logic             MEM_Write_o,
    output logic             RegWrite_o,
    output logic [1:0]       RegDst_o,
    output logic [1:0]       MEM2Reg_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [2:0]       ALU_op_o,
    output logic [1:0]       PCSrc_o,
    output logic             Branch_o,
    output logic             instr_done_o,
    output logic             illegal_o,
    output logic             timeout_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_J, C_JAL, C_BEQ, C_SLTI, C_IMM, C_LW, C_SW, C_ILL
    } cls_e;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    function automatic cls_e classify(input logic [5:0] op);
        cls_e c;
        if (op == 6'b000000)           c = C_R;
        else if (op == 6'b000010)      c = C_J;
        else if (op == 6'b000011)      c = C_JAL;
        else if (op == 6'b000100)      c = C_BEQ;
        else if (op == 6'b001010)      c = C_SLTI;
        else if (op[5:3] == 3'b001)    c = C_IMM;
        else if (op == 6'b100011)      c = C_LW;
        else if (op == 6'b101011)      c = C_SW;
        else                           c = C_ILL;
        return c;
    endfunction

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [5:0]        op_q, op_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;

    cls_e cls_in, cls_q;
    logic pc_w, ir_w, mem_rd, mem_wr, reg_w, done, ill, tmo;

    assign cls_in = classify(instr_op_i);
    assign cls_q  = classify(op_q);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        op_d       = op_q;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_w      = 1'b0;
        done       = 1'b0;
        ill        = 1'b0;
        tmo        = 1'b0;
        IorD_o     = 1'b0;
        RegDst_o   = 2'b00;
        MEM2Reg_o  = 2'b00;
        ALUSrcA_o  = 1'b0;
        ALUSrcB_o  = 2'b00;
        ALU_op_o   = 3'b000;
        PCSrc_o    = 2'b00;
        Branch_o   = 1'b0;
        unique case (state_q)
            FETCH: begin
                mem_rd    = 1'b1;
                ALUSrcB_o = 2'b01;
                ALU_op_o  = 3'b100;
                if (mem_ready_i) begin
                    ir_w    = 1'b1;
                    pc_w    = 1'b1;
                    state_d = DECODE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    tmo = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DECODE: begin
                op_d      = instr_op_i;
                ALUSrcB_o = 2'b11;
                ALU_op_o  = 3'b100;
                case (cls_in)
                    C_J: begin
                        pc_w    = 1'b1;
                        PCSrc_o = 2'b10;
                        done    = 1'b1;
                        state_d = FETCH;
                    end
                    C_JAL:   state_d = WB;
                    C_ILL: begin
                        ill     = 1'b1;
                        state_d = FETCH;
                    end
                    default: state_d = EXEC;
                endcase
            end
            EXEC: begin
                ALUSrcA_o = 1'b1;
                state_d   = WB;
                case (cls_q)
                    C_R: begin
                        ALUSrcB_o = 2'b00;
                        ALU_op_o  = 3'b010;
                    end
                    C_SLTI: begin
                        ALUSrcB_o = 2'b10;
                        ALU_op_o  = 3'b111;
                    end
                    C_LW, C_SW: begin
                        ALUSrcB_o = 2'b10;
                        ALU_op_o  = 3'b100;
                        state_d   = MEM;
                    end
                    C_BEQ: begin
                        ALUSrcB_o = 2'b00;
                        ALU_op_o  = 3'b101;
                        Branch_o  = 1'b1;
                        PCSrc_o   = 2'b01;
                        pc_w      = zero_i;
                        done      = 1'b1;
                        state_d   = FETCH;
                    end
                    default: begin
                        ALUSrcB_o = 2'b10;
                        ALU_op_o  = 3'b100;
                    end
                endcase
            end
            MEM: begin
                IorD_o = 1'b1;
                mem_rd = (cls_q == C_LW);
                mem_wr = (cls_q == C_SW);
                if (mem_ready_i) begin
                    if (cls_q == C_LW) begin
                        state_d = WB;
                    end else begin
                        done    = 1'b1;
                        state_d = FETCH;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    tmo     = 1'b1;
                    state_d = FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            WB: begin
                reg_w   = 1'b1;
                done    = 1'b1;
                state_d = FETCH;
                case (cls_q)
                    C_R:  RegDst_o = 2'b01;
                    C_LW: MEM2Reg_o = 2'b01;
                    C_JAL: begin
                        RegDst_o  = 2'b10;
                        MEM2Reg_o = 2'b10;
                        pc_w      = 1'b1;
                        PCSrc_o   = 2'b10;
                    end
                    default: ;
                endcase
            end
            default: state_d = FETCH;
        endcase
    end

    // Strobes and pulses are masked during reset so nothing leaks onto the datapath.
    assign PC_Write_o   = pc_w   & ~rst_i;
    assign IR_Write_o   = ir_w   & ~rst_i;
    assign MEM_Read_o   = mem_rd & ~rst_i;
    assign MEM_Write_o  = mem_wr & ~rst_i;
    assign RegWrite_o   = reg_w  & ~rst_i;
    assign instr_done_o = done   & ~rst_i;
    assign illegal_o    = ill    & ~rst_i;
    assign timeout_o    = tmo    & ~rst_i;
    assign state_o      = state_q;
    assign instr_cnt_o  = instr_cnt_q;

    assign instr_cnt_d = instr_cnt_q + (done ? CNT_W'(1) : CNT_W'(0));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= FETCH;
            wait_cnt_q  <= '0;
            op_q        <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            op_q        <= op_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instruction streams
// checked cycle by cycle against a phase-list model of each instruction class.
module tb_multicycle_ctrl;

    localparam int MAX_WAIT = 3;
    localparam int CNT_W    = 4;

    localparam int R = 0, J = 1, JAL = 2, BEQ = 3, SLTI = 4, IMM = 5, LW = 6, SW = 7, ILL = 8;

    typedef struct packed {
        logic       pc_w, ir_w, iord, mrd, mwr, rw;
        logic [1:0] rdst, m2r;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] pcs;
        logic       br, done, ill, to;
        logic [2:0] st;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [5:0] instr_op = '0;
    logic zero = 1'b0, mem_ready = 1'b0;
    logic PC_Write, IR_Write, IorD, MEM_Read, MEM_Write, RegWrite, ALUSrcA, Branch;
    logic instr_done, illegal, timeout;
    logic [1:0] RegDst, MEM2Reg, ALUSrcB, PCSrc;
    logic [2:0] ALU_op, state;
    logic [CNT_W-1:0] instr_cnt;

    int n_vec = 0, n_err = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    vec_t dut_vec;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .instr_op_i(instr_op), .zero_i(zero), .mem_ready_i(mem_ready),
        .PC_Write_o(PC_Write), .IR_Write_o(IR_Write), .IorD_o(IorD), .MEM_Read_o(MEM_Read),
        .MEM_Write_o(MEM_Write), .RegWrite_o(RegWrite), .RegDst_o(RegDst), .MEM2Reg_o(MEM2Reg),
        .ALUSrcA_o(ALUSrcA), .ALUSrcB_o(ALUSrcB), .ALU_op_o(ALU_op), .PCSrc_o(PCSrc),
        .Branch_o(Branch), .instr_done_o(instr_done), .illegal_o(illegal), .timeout_o(timeout),
        .state_o(state), .instr_cnt_o(instr_cnt)
    );

    assign dut_vec = {PC_Write, IR_Write, IorD, MEM_Read, MEM_Write, RegWrite, RegDst, MEM2Reg,
                      ALUSrcA, ALUSrcB, ALU_op, PCSrc, Branch, instr_done, illegal, timeout, state};

    function automatic int cls_of(input logic [5:0] op);
        if (op == 6'h00) return R;
        if (op == 6'h02) return J;
        if (op == 6'h03) return JAL;
        if (op == 6'h04) return BEQ;
        if (op == 6'h0A) return SLTI;
        if (op >= 6'h08 && op <= 6'h0F) return IMM;
        if (op == 6'h23) return LW;
        if (op == 6'h2B) return SW;
        return ILL;
    endfunction

    // Expected outputs for one cycle spent in phase ph by an instruction of class c.
    function automatic vec_t expect_vec(input int ph, input int c, input logic z,
                                        input logic rdy, input logic to);
        vec_t v = '0;
        v.st = 3'(ph);
        case (ph)
            0: begin
                v.mrd = 1'b1; v.asb = 2'b01; v.aop = 3'b100;
                v.ir_w = rdy; v.pc_w = rdy; v.to = to;
            end
            1: begin
                v.asb = 2'b11; v.aop = 3'b100;
                if (c == J) begin v.pc_w = 1'b1; v.pcs = 2'b10; v.done = 1'b1; end
                if (c == ILL) v.ill = 1'b1;
            end
            2: begin
                v.asa = 1'b1;
                case (c)
                    R:    begin v.asb = 2'b00; v.aop = 3'b010; end
                    SLTI: begin v.asb = 2'b10; v.aop = 3'b111; end
                    BEQ:  begin
                        v.asb = 2'b00; v.aop = 3'b101; v.br = 1'b1;
                        v.pcs = 2'b01; v.pc_w = z; v.done = 1'b1;
                    end
                    default: begin v.asb = 2'b10; v.aop = 3'b100; end
                endcase
            end
            3: begin
                v.iord = 1'b1; v.mrd = (c == LW); v.mwr = (c == SW);
                v.done = rdy && (c == SW); v.to = to;
            end
            default: begin
                v.rw = 1'b1; v.done = 1'b1;
                if (c == R) v.rdst = 2'b01;
                if (c == LW) v.m2r = 2'b01;
                if (c == JAL) begin
                    v.rdst = 2'b10; v.m2r = 2'b10; v.pc_w = 1'b1; v.pcs = 2'b10;
                end
            end
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, compare at negedge, return 1ns after the next rising edge.
    // The opcode bus carries junk outside DECODE to prove later phases use the latched copy.
    task automatic cycle(input int ph, input int c, input logic [5:0] op, input logic z,
                         input logic rdy, input logic to);
        instr_op  = (ph == 1) ? op : 6'($urandom);
        zero      = z;
        mem_ready = rdy;
        @(negedge clk);
        chk($sformatf("outputs ph%0d cls%0d", ph, c), 32'(dut_vec), 32'(expect_vec(ph, c, z, rdy, to)));
        chk("instr_cnt", 32'(instr_cnt), 32'(exp_cnt));
        @(posedge clk);
        #1;
    endtask

    // Memory phase with w not-ready cycles; returns 0 if it timed out.
    task automatic mem_phase(input int ph, input int c, input logic [5:0] op, input logic z,
                             input int w, output bit ok);
        if (w >= MAX_WAIT) begin
            for (int i = 0; i < MAX_WAIT; i++) cycle(ph, c, op, z, 1'b0, i == MAX_WAIT - 1);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < w; i++) cycle(ph, c, op, z, 1'b0, 1'b0);
            cycle(ph, c, op, z, 1'b1, 1'b0);
            ok = 1'b1;
        end
    endtask

    task automatic run(input logic [5:0] op, input logic z, input int fw, input int mw);
        int c = cls_of(op);
        bit ok;
        mem_phase(0, c, op, z, fw, ok);
        if (!ok) return;
        cycle(1, c, op, z, 1'($urandom), 1'b0);
        if (c == ILL) return;
        if (c == J) begin exp_cnt++; return; end
        if (c != JAL) begin
            cycle(2, c, op, z, 1'($urandom), 1'b0);
            if (c == BEQ) begin exp_cnt++; return; end
            if (c == LW || c == SW) begin
                mem_phase(3, c, op, z, mw, ok);
                if (!ok) return;
                if (c == SW) begin exp_cnt++; return; end
            end
        end
        cycle(4, c, op, z, 1'($urandom), 1'b0);
        exp_cnt++;
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] op;
        case ($urandom_range(0, 8))
            0: op = 6'h00;
            1: op = 6'h02;
            2: op = 6'h03;
            3: op = 6'h04;
            4: op = 6'h0A;
            5: begin op = {3'b001, 3'($urandom)}; if (op == 6'h0A) op = 6'h0B; end
            6: op = 6'h23;
            7: op = 6'h2B;
            default: begin
                op = 6'h3F;
                for (int k = 0; k < 20; k++) begin
                    op = 6'($urandom);
                    if (cls_of(op) == ILL) break;
                end
                if (cls_of(op) != ILL) op = 6'h3F;
            end
        endcase
        return op;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_ready = 1'b1;
        instr_op  = 6'h2B;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset strobes", 32'({PC_Write, IR_Write, MEM_Read, MEM_Write, RegWrite,
                                  instr_done, illegal, timeout}), 32'(0));
        chk("reset state", 32'(state), 32'(0));
        chk("reset cnt", 32'(instr_cnt), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        run(6'h00, 1'b0, 0, 0);                 // R-type, no waits
        chk("cnt after R", 32'(instr_cnt), 32'(1));
        run(6'h23, 1'b0, 0, 2);                 // lw with two memory wait cycles
        run(6'h04, 1'b1, 0, 0);                 // beq taken
        run(6'h04, 1'b0, 0, 0);                 // beq not taken
        run(6'h03, 1'b0, 1, 0);                 // jal after one fetch wait
        run(6'h3F, 1'b0, 0, 0);                 // illegal
        run(6'h0A, 1'b0, 0, 0);                 // slti
        run(6'h0D, 1'b0, 0, 0);                 // imm
        run(6'h2B, 1'b0, 0, MAX_WAIT);          // sw memory timeout
        run(6'h00, 1'b0, MAX_WAIT, 0);          // fetch timeout
        chk("cnt after timeouts", 32'(instr_cnt), 32'(exp_cnt));

        // Reset arriving in the middle of a sw memory access.
        cycle(0, SW, 6'h2B, 1'b0, 1'b1, 1'b0);
        cycle(1, SW, 6'h2B, 1'b0, 1'b0, 1'b0);
        cycle(2, SW, 6'h2B, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("sw mem write", 32'(MEM_Write), 32'(1));
        #1 rst = 1'b1;
        #1;
        chk("rst drops write", 32'(MEM_Write), 32'(0));
        chk("rst state", 32'(state), 32'(0));
        chk("rst cnt", 32'(instr_cnt), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = '0;

        for (int i = 0; i < 16; i++) run(6'h02, 1'b0, 0, 0);
        chk("cnt wrap", 32'(instr_cnt), 32'(0));

        for (int i = 0; i < 80; i++)
            run(rand_op(), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        chk("cnt final", 32'(instr_cnt), 32'(exp_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
